adder_lane_scheduler: RTL and testbench
=======================================

# adder_lane_scheduler

Issue scheduler in front of one `config_adder` instance. It shares the adder between two half-precision requesters (lanes H0, H1) and one full-precision requester (F). When both half lanes have work, they are packed into a single halved-precision operation. The adder result is registered and returned on per-requester valid/ready result channels. The block sits between the operand sources of the compute array and the shared adder.

## Interface
Parameters:
- `P`, default 8: full operand width. Must be even and ≥ 4. Half lanes are P/2 bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `h0_valid`, `h1_valid`  in  1  half-lane request valid.
- `h0_ready`, `h1_ready`  out  1  half-lane request accepted this cycle.
- `h0_a`, `h0_b`, `h1_a`, `h1_b`  in  P/2  signed half-lane operands.
- `f_valid`  in  1  full request valid.
- `f_ready`  out  1  full request accepted this cycle.
- `f_a`, `f_b`  in  P  signed full operands.
- `h0_res_valid`, `h1_res_valid`, `f_res_valid`  out  1  result valid.
- `h0_res_ready`, `h1_res_ready`, `f_res_ready`  in  1  result consumer ready.
- `h0_res`, `h1_res`  out  P/2+1  signed half sum.
- `f_res`  out  P+1  signed full sum.
- `pack_cnt`  out  16  count of issues that carried both half lanes; wraps at 2^16.

## Operation
- Instantiates one `config_adder #(P)`. Mode and operands are muxed combinationally from the grant.
- Each requester owns a 1-entry result register (data + valid).
- Slot free for requester X means `X_res_valid == 0` or (`X_res_valid && X_res_ready`) in the same cycle. This allows a same-cycle drain-and-refill.
- Eligibility:
  - F is eligible when `f_valid` is high and the F slot is free.
  - Lane Hk is eligible when `hk_valid` is high and the Hk slot is free.
  - The H group is eligible if either lane is eligible.
- Arbitration is one grant per cycle:
  - If only F or only H is eligible, grant it.
  - If both are eligible, round-robin on a 1-bit `last_was_f`: grant F when `last_was_f == 0`, else grant H.
  - `last_was_f` updates only on a contested grant.
  - Reset value of `last_was_f` is 0, so F wins the first contest.
- H grant: `halvedPrecision = 1`. Operand a = {h1_a, h0_a}; operand b = {h1_b, h0_b}. A non-eligible lane drives zeros.
  - Every eligible lane is accepted. `hk_ready` is high only for eligible lanes.
  - When both lanes are accepted, `pack_cnt` increments by 1.
- F grant: `halvedPrecision = 0`, operands are `f_a` / `f_b`, and `f_ready = 1`.
- Ready outputs may depend combinationally on valids and result readies. Valid outputs never depend on ready inputs.
- Result capture on an accept edge:
  - `h0_res` ← adder sum[P/2:0].
  - `h1_res` ← adder sum[P+1:P/2+1].
  - `f_res` ← adder sum[P:0].
  - The matching `res_valid` is set to 1.
- Result hold: `res_valid` is cleared when `res_ready` is seen without a refill. While `res_valid` is high and `res_ready` is low, `res` data stays stable.
- Arithmetic: two's complement with full precision and no overflow. A half sum is P/2+1 bits; a full sum is P+1 bits.

## Timing
- Latency: request accept edge to `res_valid` is exactly 1 cycle.
- Throughput is 1 issue per cycle:
  - Up to 2 half results per cycle, or 1 full result per cycle.
  - Under sustained contention, F and H alternate.
- Reset, asynchronous on `rst_n` low:
  - All `*_res_valid` = 0, all `*_res` = 0, `pack_cnt` = 0, `last_was_f` = 0.
  - While reset is asserted, all `*_ready` = 0.
  - Reset mid-operation discards in-flight results immediately, with no further handshake.
- Backpressure: a stalled result slot blocks only its own requester. A stalled H0 slot does not block H1 or F.
- Idle (no valids): the adder inputs are don't-care, and no state changes except result draining.

## Test plan
P = 8 for all scenarios.
- **Packed half add:** H0 a=0x7, b=0x7 and H1 a=0x8, b=0xF in the same cycle, F idle.
  - Required: both readies = 1.
  - Next cycle `h0_res` = 5'h0E and `h1_res` = 5'h17 (−9), both valid.
  - `pack_cnt` = 1.
- **Full add extremes:**
  - f_a = 0x7F, f_b = 0x01 → `f_res` = 9'h080, 1 cycle later.
  - Then 0x80 + 0x80 → `f_res` = 9'h100.
  - `pack_cnt` stays 0.
- **Contention fairness:** F and H0 held valid for 6 cycles, all res_ready = 1, starting from reset.
  - Required grant sequence: F, H, F, H, F, H.
  - 3 results on each of F and H0.
- **Single lane:** only H1 valid, a=0x3, b=0x2 → `h1_res` = 5'h05; H0 slot untouched; `pack_cnt` unchanged.
- **Backpressure isolation:** `h0_res_valid` = 1 with `h0_res_ready` = 0, and new H0 and H1 requests valid.
  - Required: `h0_ready` = 0 and `h1_ready` = 1.
  - `h0_res` is stable until ready.
  - Raising ready accepts the new H0 in that same cycle.
- **Async reset mid-flight:** `rst_n` driven low between clock edges while `f_res_valid` = 1.
  - Required: `f_res_valid` = 0 immediately.
  - After release, the first contested grant goes to F.

Source files
------------

// File: rtl/adder_lane_scheduler.sv
// Issue scheduler sharing one configurable adder between two half-precision lanes
// and one full-precision requester, with registered per-requester result slots.

module config_adder #(
    parameter int P = 8
) (
    input  logic [P-1:0] a,
    input  logic [P-1:0] b,
    input  logic         halved_precision,
    output logic [P+1:0] sum
);
    localparam int H = P / 2;

    logic signed [H:0] lo_sum;
    logic signed [H:0] hi_sum;
    logic signed [P:0] full_sum;

    assign lo_sum   = $signed({a[H-1], a[H-1:0]}) + $signed({b[H-1], b[H-1:0]});
    assign hi_sum   = $signed({a[P-1], a[P-1:H]}) + $signed({b[P-1], b[P-1:H]});
    assign full_sum = $signed({a[P-1], a}) + $signed({b[P-1], b});

    // Halved mode packs two independent (H+1)-bit sums; full mode sign-extends one sum.
    assign sum = halved_precision ? {hi_sum, lo_sum} : {full_sum[P], full_sum};
endmodule

module adder_lane_scheduler #(
    parameter int P = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             h0_valid,
    input  logic             h1_valid,
    output logic             h0_ready,
    output logic             h1_ready,
    input  logic [P/2-1:0]   h0_a,
    input  logic [P/2-1:0]   h0_b,
    input  logic [P/2-1:0]   h1_a,
    input  logic [P/2-1:0]   h1_b,
    input  logic             f_valid,
    output logic             f_ready,
    input  logic [P-1:0]     f_a,
    input  logic [P-1:0]     f_b,
    output logic             h0_res_valid,
    output logic             h1_res_valid,
    output logic             f_res_valid,
    input  logic             h0_res_ready,
    input  logic             h1_res_ready,
    input  logic             f_res_ready,
    output logic [P/2:0]     h0_res,
    output logic [P/2:0]     h1_res,
    output logic [P:0]       f_res,
    output logic [15:0]      pack_cnt
);
    localparam int H = P / 2;

    logic         f_free, h0_free, h1_free;
    logic         f_elig, h0_elig, h1_elig, h_elig;
    logic         grant_f, grant_h;
    logic         h0_take, h1_take;
    logic         last_was_f;
    logic [P-1:0] add_a, add_b;
    logic         add_halved;
    logic [P+1:0] add_sum;

    assign f_free  = !f_res_valid  || f_res_ready;
    assign h0_free = !h0_res_valid || h0_res_ready;
    assign h1_free = !h1_res_valid || h1_res_ready;

    // Readies are forced low while reset is held, so nothing is accepted then.
    assign f_elig  = rst_n && f_valid  && f_free;
    assign h0_elig = rst_n && h0_valid && h0_free;
    assign h1_elig = rst_n && h1_valid && h1_free;
    assign h_elig  = h0_elig || h1_elig;

    assign grant_f = f_elig && (!h_elig || !last_was_f);
    assign grant_h = h_elig && (!f_elig ||  last_was_f);

    assign h0_take  = grant_h && h0_elig;
    assign h1_take  = grant_h && h1_elig;
    assign f_ready  = grant_f;
    assign h0_ready = h0_take;
    assign h1_ready = h1_take;

    always_comb begin
        add_a      = '0;
        add_b      = '0;
        add_halved = 1'b0;
        if (grant_h) begin
            add_halved = 1'b1;
            if (h0_take) begin
                add_a[H-1:0] = h0_a;
                add_b[H-1:0] = h0_b;
            end
            if (h1_take) begin
                add_a[P-1:H] = h1_a;
                add_b[P-1:H] = h1_b;
            end
        end else if (grant_f) begin
            add_a = f_a;
            add_b = f_b;
        end
    end

    config_adder #(.P(P)) u_adder (
        .a                (add_a),
        .b                (add_b),
        .halved_precision (add_halved),
        .sum              (add_sum)
    );

    // Round-robin pointer only moves when F and H actually competed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_was_f <= 1'b0;
            pack_cnt   <= '0;
        end else begin
            if (f_elig && h_elig)
                last_was_f <= grant_f;
            if (h0_take && h1_take)
                pack_cnt <= pack_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_res_valid <= 1'b0;
            f_res       <= '0;
        end else if (grant_f) begin
            f_res_valid <= 1'b1;
            f_res       <= add_sum[P:0];
        end else if (f_res_ready) begin
            f_res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0_res_valid <= 1'b0;
            h0_res       <= '0;
        end else if (h0_take) begin
            h0_res_valid <= 1'b1;
            h0_res       <= add_sum[H:0];
        end else if (h0_res_ready) begin
            h0_res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_res_valid <= 1'b0;
            h1_res       <= '0;
        end else if (h1_take) begin
            h1_res_valid <= 1'b1;
            h1_res       <= add_sum[P+1:H+1];
        end else if (h1_res_ready) begin
            h1_res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adder_lane_scheduler.sv
// Bench for adder_lane_scheduler: directed scenarios plus random traffic against a
// cycle-level reference model of the issue and result-slot rules.

module tb_adder_lane_scheduler;
    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       h0_valid = 0, h1_valid = 0, f_valid = 0;
    logic       h0_ready, h1_ready, f_ready;
    logic [3:0] h0_a = 0, h0_b = 0, h1_a = 0, h1_b = 0;
    logic [7:0] f_a = 0, f_b = 0;
    logic       h0_res_valid, h1_res_valid, f_res_valid;
    logic       h0_res_ready = 0, h1_res_ready = 0, f_res_ready = 0;
    logic [4:0] h0_res, h1_res;
    logic [8:0] f_res;
    logic [15:0] pack_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit         m_fv, m_h0v, m_h1v, m_last;
    logic [8:0] m_fd;
    logic [4:0] m_h0d, m_h1d;
    int         m_pack;

    adder_lane_scheduler #(.P(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .h0_valid(h0_valid), .h1_valid(h1_valid),
        .h0_ready(h0_ready), .h1_ready(h1_ready),
        .h0_a(h0_a), .h0_b(h0_b), .h1_a(h1_a), .h1_b(h1_b),
        .f_valid(f_valid), .f_ready(f_ready), .f_a(f_a), .f_b(f_b),
        .h0_res_valid(h0_res_valid), .h1_res_valid(h1_res_valid), .f_res_valid(f_res_valid),
        .h0_res_ready(h0_res_ready), .h1_res_ready(h1_res_ready), .f_res_ready(f_res_ready),
        .h0_res(h0_res), .h1_res(h1_res), .f_res(f_res),
        .pack_cnt(pack_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fv = 0; m_h0v = 0; m_h1v = 0; m_last = 0;
        m_fd = '0; m_h0d = '0; m_h1d = '0; m_pack = 0;
    endtask

    // Called with inputs already driven while clk is low; checks, advances the model
    // across the coming rising edge, and returns at the following falling edge.
    task automatic cycle();
        bit ef, e0, e1, eh, gf, gh;
        int s;
        #1;
        ef = f_valid  && (!m_fv  || f_res_ready);
        e0 = h0_valid && (!m_h0v || h0_res_ready);
        e1 = h1_valid && (!m_h1v || h1_res_ready);
        eh = e0 || e1;
        if (ef && eh) begin
            gf = !m_last;
            gh = m_last;
        end else begin
            gf = ef;
            gh = eh;
        end
        chk("f_ready",  f_ready,  gf);
        chk("h0_ready", h0_ready, gh && e0);
        chk("h1_ready", h1_ready, gh && e1);
        chk("f_res_valid",  f_res_valid,  m_fv);
        chk("h0_res_valid", h0_res_valid, m_h0v);
        chk("h1_res_valid", h1_res_valid, m_h1v);
        chk("f_res",  f_res,  m_fd);
        chk("h0_res", h0_res, m_h0d);
        chk("h1_res", h1_res, m_h1d);
        chk("pack_cnt", pack_cnt, m_pack[15:0]);

        if (ef && eh) m_last = gf;
        if (gf) begin
            s = int'($signed(f_a)) + int'($signed(f_b));
            m_fd = s[8:0]; m_fv = 1;
        end else if (f_res_ready) m_fv = 0;
        if (gh && e0) begin
            s = int'($signed(h0_a)) + int'($signed(h0_b));
            m_h0d = s[4:0]; m_h0v = 1;
        end else if (h0_res_ready) m_h0v = 0;
        if (gh && e1) begin
            s = int'($signed(h1_a)) + int'($signed(h1_b));
            m_h1d = s[4:0]; m_h1v = 1;
        end else if (h1_res_ready) m_h1v = 0;
        if (gh && e0 && e1) m_pack = (m_pack + 1) % 65536;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        f_valid = 0; h0_valid = 0; h1_valid = 0;
        f_res_ready = 1; h0_res_ready = 1; h1_res_ready = 1;
    endtask

    initial begin
        int nf, nh;
        logic [4:0] held;
        model_reset();
        f_valid = 1; h0_valid = 1;
        #2;
        chk("rst f_ready", f_ready, 0);
        chk("rst h0_ready", h0_ready, 0);
        chk("rst f_res_valid", f_res_valid, 0);
        chk("rst f_res", f_res, 0);
        chk("rst pack_cnt", pack_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // Contention from reset: F, H, F, H, F, H
        idle_inputs();
        f_valid = 1; h0_valid = 1;
        nf = 0; nh = 0;
        for (int i = 0; i < 6; i++) begin
            f_a = 8'($urandom); f_b = 8'($urandom);
            h0_a = 4'($urandom); h0_b = 4'($urandom);
            #1;
            chk("contend grant_f", f_ready, (i % 2 == 0) ? 1 : 0);
            nf += f_ready; nh += h0_ready;
            cycle();
        end
        chk("contend f count", nf, 3);
        chk("contend h count", nh, 3);

        // Packed half add
        idle_inputs();
        cycle();
        h0_valid = 1; h0_a = 4'h7; h0_b = 4'h7;
        h1_valid = 1; h1_a = 4'h8; h1_b = 4'hF;
        #1;
        chk("pack h0_ready", h0_ready, 1);
        chk("pack h1_ready", h1_ready, 1);
        cycle();
        h0_valid = 0; h1_valid = 0;
        chk("pack h0_res", h0_res, 5'h0E);
        chk("pack h1_res", h1_res, 5'h17);
        chk("pack cnt", pack_cnt, 1);

        // Full extremes
        f_valid = 1; f_a = 8'h7F; f_b = 8'h01;
        cycle();
        chk("full 7f+01", f_res, 9'h080);
        f_a = 8'h80; f_b = 8'h80;
        cycle();
        chk("full 80+80", f_res, 9'h100);
        chk("full pack_cnt", pack_cnt, 1);
        f_valid = 0;
        cycle();

        // Single lane H1
        held = h0_res;
        h1_valid = 1; h1_a = 4'h3; h1_b = 4'h2;
        cycle();
        h1_valid = 0;
        chk("single h1_res", h1_res, 5'h05);
        chk("single h0_res", h0_res, held);
        chk("single h0_valid", h0_res_valid, 0);
        chk("single pack", pack_cnt, 1);

        // Backpressure isolation
        h0_valid = 1; h0_a = 4'h1; h0_b = 4'h2;
        h0_res_ready = 0;
        cycle();
        held = h0_res;
        h0_a = 4'h5; h0_b = 4'h4; h1_valid = 1; h1_a = 4'h6; h1_b = 4'h1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp h0_ready", h0_ready, 0);
            chk("bp h1_ready", h1_ready, 1);
            chk("bp h0_res stable", h0_res, held);
            cycle();
        end
        h1_valid = 0;
        h0_res_ready = 1;
        #1;
        chk("bp refill h0_ready", h0_ready, 1);
        cycle();
        chk("bp refill h0_res", h0_res, 5'h09);
        h0_valid = 0;

        // Async reset mid-flight
        f_valid = 1; f_a = 8'h12; f_b = 8'h34;
        cycle();
        f_res_ready = 0;
        #2;
        rst_n = 0;
        #1;
        chk("arst f_res_valid", f_res_valid, 0);
        chk("arst f_res", f_res, 0);
        chk("arst f_ready", f_ready, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        idle_inputs();
        f_valid = 1; h1_valid = 1; f_a = 8'h01; f_b = 8'h02;
        #1;
        chk("arst first contest f", f_ready, 1);
        chk("arst first contest h1", h1_ready, 0);
        cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            f_valid  = ($urandom_range(0, 3) != 0);
            h0_valid = ($urandom_range(0, 2) != 0);
            h1_valid = ($urandom_range(0, 2) != 0);
            f_res_ready  = ($urandom_range(0, 3) != 0);
            h0_res_ready = ($urandom_range(0, 3) != 0);
            h1_res_ready = ($urandom_range(0, 3) != 0);
            f_a = 8'($urandom); f_b = 8'($urandom);
            h0_a = 4'($urandom); h0_b = 4'($urandom);
            h1_a = 4'($urandom); h1_b = 4'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
